// File: rtl/fixed_relu6_backward.sv
// ReLU6 backward pass: buffers per-lane activation masks and gates incoming
// gradients with them, pairing gradient beats with mask beats in arrival order.
module fixed_relu6_backward #(
   parameter int DATA_IN_0_PRECISION_0       = 8,
   parameter int DATA_IN_0_PRECISION_1       = 3,
   parameter int GRAD_PRECISION_0            = 8,
   parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
   parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
   parameter int MASK_FIFO_DEPTH             = 8
) (
   input  logic rst,
   input  logic clk,

   input  logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1*DATA_IN_0_PRECISION_0-1:0] act_in_0,
   input  logic act_in_0_valid,
   output logic act_in_0_ready,

   input  logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1*GRAD_PRECISION_0-1:0] dy_in_0,
   input  logic dy_in_0_valid,
   output logic dy_in_0_ready,

   output logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1*GRAD_PRECISION_0-1:0] dx_out_0,
   output logic dx_out_0_valid,
   input  logic dx_out_0_ready,

   output logic [$clog2(MASK_FIFO_DEPTH+1)-1:0] mask_count
);

   localparam int P  = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
   localparam int AW = DATA_IN_0_PRECISION_0;
   localparam int GW = GRAD_PRECISION_0;
   localparam int EW = AW + 4;
   localparam int PW = $clog2(MASK_FIFO_DEPTH);
   localparam int CW = $clog2(MASK_FIFO_DEPTH + 1);

   localparam logic [CW-1:0]        FULL_COUNT = CW'(MASK_FIFO_DEPTH);
   localparam logic signed [EW-1:0] RELU6_MAX  = EW'(6);

   if ((MASK_FIFO_DEPTH < 2) || ((MASK_FIFO_DEPTH & (MASK_FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("MASK_FIFO_DEPTH must be a power of two and at least 2");
   end
   if ((DATA_IN_0_PRECISION_1 < 0) || (DATA_IN_0_PRECISION_1 >= DATA_IN_0_PRECISION_0)) begin : g_bad_frac
      $error("DATA_IN_0_PRECISION_1 must lie in [0, DATA_IN_0_PRECISION_0)");
   end

   // mask storage and FIFO bookkeeping
   logic [P-1:0]  mask_mem [MASK_FIFO_DEPTH];
   logic [P-1:0]  mask_in;
   logic [P-1:0]  head_mask;
   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic          fifo_full;
   logic          fifo_empty;
   logic          push;
   logic          pop;

   // output beat register
   logic [P*GW-1:0] dx_reg;
   logic [P*GW-1:0] dx_next;
   logic            dx_valid_reg;

   // Ready flags depend only on registered state (plus the downstream ready
   // for dy), so a pop never frees a slot for a push in the same cycle.
   assign fifo_full      = (count_reg == FULL_COUNT);
   assign fifo_empty     = (count_reg == '0);
   assign act_in_0_ready = !fifo_full;
   assign dy_in_0_ready  = !fifo_empty && (!dx_valid_reg || dx_out_0_ready);
   assign push           = act_in_0_valid && act_in_0_ready;
   assign pop            = dy_in_0_valid && dy_in_0_ready;
   assign head_mask      = mask_mem[rd_ptr_reg];

   // Per-lane mask generation and gradient gating. The activation is
   // sign-extended so the comparison against 6 stays exact for narrow words.
   for (genvar gi = 0; gi < P; gi++) begin : g_lane
      logic signed [EW-1:0] act_lane;
      logic                 act_pos;
      logic                 act_le6;

      assign act_lane    = EW'($signed(act_in_0[gi*AW +: AW]));
      assign act_pos     = !act_lane[EW-1] && (act_lane != '0);
      assign act_le6     = (act_lane <= RELU6_MAX);
      assign mask_in[gi] = act_pos && act_le6;

      assign dx_next[gi*GW +: GW] = head_mask[gi] ? dy_in_0[gi*GW +: GW] : '0;
   end

   // Mask storage has no reset: stale entries are unreachable once the
   // pointers and occupancy are cleared.
   always_ff @(posedge clk) begin
      if (push) begin
         mask_mem[wr_ptr_reg] <= mask_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // A stalled beat holds; a pop always loads a fresh beat (pop implies the
   // register is free or being drained this cycle).
   always_ff @(posedge clk) begin
      if (rst) begin
         dx_reg       <= '0;
         dx_valid_reg <= 1'b0;
      end else if (pop) begin
         dx_reg       <= dx_next;
         dx_valid_reg <= 1'b1;
      end else if (dx_out_0_ready) begin
         dx_valid_reg <= 1'b0;
      end
   end

   assign dx_out_0       = dx_reg;
   assign dx_out_0_valid = dx_valid_reg;
   assign mask_count     = count_reg;

endmodule

// File: tb/tb_fixed_relu6_backward.sv
// Scoreboard bench for fixed_relu6_backward (P=1, 8-bit words, mask depth 4).
module tb_fixed_relu6_backward;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 100;

   logic       rst = 1'b1;
   logic       clk = 1'b0;
   logic [7:0] act_in_0 = '0;
   logic       act_in_0_valid = 1'b0;
   logic       act_in_0_ready;
   logic [7:0] dy_in_0 = '0;
   logic       dy_in_0_valid = 1'b0;
   logic       dy_in_0_ready;
   logic [7:0] dx_out_0;
   logic       dx_out_0_valid;
   logic       dx_out_0_ready = 1'b1;
   logic [2:0] mask_count;

   fixed_relu6_backward #(
      .DATA_IN_0_PRECISION_0      (8),
      .DATA_IN_0_PRECISION_1      (3),
      .GRAD_PRECISION_0           (8),
      .DATA_IN_0_PARALLELISM_DIM_0(1),
      .DATA_IN_0_PARALLELISM_DIM_1(1),
      .MASK_FIFO_DEPTH            (DEPTH)
   ) dut (
      .rst           (rst),
      .clk           (clk),
      .act_in_0      (act_in_0),
      .act_in_0_valid(act_in_0_valid),
      .act_in_0_ready(act_in_0_ready),
      .dy_in_0       (dy_in_0),
      .dy_in_0_valid (dy_in_0_valid),
      .dy_in_0_ready (dy_in_0_ready),
      .dx_out_0      (dx_out_0),
      .dx_out_0_valid(dx_out_0_valid),
      .dx_out_0_ready(dx_out_0_ready),
      .mask_count    (mask_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fails  = 0;
   int cyc      = 0;
   bit started  = 1'b0;
   bit rand_on  = 1'b0;

   logic signed [7:0] act_q[$];
   logic [7:0]        exp_q[$];
   logic [7:0]        out_log[$];
   int                m_count = 0;
   bit                m_valid = 1'b0;
   bit                prev_stall = 1'b0;
   logic [7:0]        prev_dx = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input longint actual, input longint expected);
      n_checks++;
      if (actual !== expected) begin
         n_fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
      end
   endtask

   function automatic bit relu6_pass(input logic signed [7:0] a);
      return (a > 8'sd0) && (a <= 8'sd6);
   endfunction

   // Reference model and scoreboard, evaluated mid-cycle.
   always @(negedge clk) begin
      if (started) begin
         bit af, df, of;
         logic [7:0] e;
         logic signed [7:0] a;
         check_eq("mask_count", mask_count, m_count);
         check_eq("act_ready", act_in_0_ready, m_count != DEPTH);
         check_eq("dy_ready", dy_in_0_ready, (m_count != 0) && (!m_valid || dx_out_0_ready));
         check_eq("dx_valid", dx_out_0_valid, m_valid);
         if (prev_stall) check_eq("dx_hold", dx_out_0, prev_dx);
         if (rst) begin
            act_q.delete();
            exp_q.delete();
            m_count    = 0;
            m_valid    = 1'b0;
            prev_stall = 1'b0;
         end else begin
            af = act_in_0_valid && act_in_0_ready;
            df = dy_in_0_valid && dy_in_0_ready;
            of = dx_out_0_valid && dx_out_0_ready;
            if (of) begin
               if (exp_q.size() == 0) begin
                  check_eq("dx_unexpected", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check_eq("dx_data", dx_out_0, e);
                  out_log.push_back(dx_out_0);
                  $display("cycle %0d: dx beat %0d (expected %0d)", cyc, dx_out_0, e);
               end
            end
            if (df) begin
               if (act_q.size() == 0) begin
                  check_eq("dy_without_mask", 1, 0);
               end else begin
                  a = act_q.pop_front();
                  exp_q.push_back(relu6_pass(a) ? dy_in_0 : 8'd0);
               end
            end
            if (af) act_q.push_back(act_in_0);
            m_count = m_count + (af ? 1 : 0) - (df ? 1 : 0);
            if (df) m_valid = 1'b1;
            else if (dx_out_0_ready) m_valid = 1'b0;
            prev_stall = dx_out_0_valid && !dx_out_0_ready;
            prev_dx    = dx_out_0;
         end
      end
   end

   // Random downstream backpressure, applied after the main driver's updates.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (rand_on) dx_out_0_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
      $fatal(1, "watchdog expired");
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic push_act(input logic [7:0] v, output int fire_cyc);
      int  waited = 0;
      bit  fired;
      act_in_0       = v;
      act_in_0_valid = 1'b1;
      do begin
         @(negedge clk);
         fired = act_in_0_ready;
         @(posedge clk);
         #1;
         waited++;
         if (!fired && waited > TIMEOUT) begin
            check_eq("act_timeout", 0, 1);
            break;
         end
      end while (!fired);
      fire_cyc       = cyc;
      act_in_0_valid = 1'b0;
   endtask

   task automatic send_dy(input logic [7:0] v, output int fire_cyc);
      int  waited = 0;
      bit  fired;
      dy_in_0       = v;
      dy_in_0_valid = 1'b1;
      do begin
         @(negedge clk);
         fired = dy_in_0_ready;
         @(posedge clk);
         #1;
         waited++;
         if (!fired && waited > TIMEOUT) begin
            check_eq("dy_timeout", 0, 1);
            break;
         end
      end while (!fired);
      fire_cyc      = cyc;
      dy_in_0_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_drained(input string tag);
      check_eq({tag, "_exp_left"}, exp_q.size(), 0);
      check_eq({tag, "_mask_left"}, act_q.size(), 0);
   endtask

   logic signed [7:0] t1_act [5] = '{-8'sd3, 8'sd0, 8'sd4, 8'sd6, 8'sd7};
   logic [7:0]        t1_exp [5] = '{8'd0, 8'd0, 8'd10, 8'd10, 8'd0};
   logic signed [7:0] t4_act [16];
   int c_act, c_dy, c_first, c_last;

   initial begin
      t4_act = '{8'sd1, 8'sd5, 8'sd6, 8'sd7, -8'sd1, -8'sd128, 8'sd127, 8'sd0,
                 8'sd2, 8'sd3, -8'sd6, 8'sd6, 8'sd8, 8'sd4, 8'sd1, -8'sd2};

      // reset
      idle(2);
      rst     = 1'b0;
      started = 1'b1;
      @(negedge clk);
      check_eq("rst_dx_data", dx_out_0, 0);
      check_eq("rst_act_ready", act_in_0_ready, 1);
      check_eq("rst_dy_ready", dy_in_0_ready, 0);
      idle(1);

      // mask boundaries: -3, 0, 4, 6, 7 against dy=10
      out_log.delete();
      fork
         begin
            int c;
            for (int i = 0; i < 5; i++) push_act(t1_act[i], c);
         end
         begin
            int c;
            idle(2);
            for (int i = 0; i < 5; i++) send_dy(8'd10, c);
         end
      join
      idle(3);
      check_eq("t1_out_count", out_log.size(), 5);
      for (int i = 0; i < 5 && i < out_log.size(); i++) check_eq("t1_dx_order", out_log[i], t1_exp[i]);
      check_drained("t1");

      // full FIFO holds off the fifth activation until the first pop
      for (int i = 0; i < 4; i++) push_act(8'(i + 1), c_act);
      @(negedge clk);
      check_eq("t2_count_full", mask_count, 4);
      check_eq("t2_act_ready_full", act_in_0_ready, 0);
      idle(1);
      fork
         push_act(8'd5, c_act);
         begin
            repeat (3) begin
               @(negedge clk);
               check_eq("t2_held", act_in_0_ready, 0);
            end
            idle(1);
            send_dy(8'd20, c_dy);
         end
      join
      check_eq("t2_accept_cycle", c_act, c_dy + 1);
      for (int i = 0; i < 4; i++) send_dy(8'(21 + i), c_dy);
      idle(3);
      check_drained("t2");

      // dy waiting on an empty FIFO
      dy_in_0       = 8'd33;
      dy_in_0_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_eq("t3_dy_ready_empty", dy_in_0_ready, 0);
         check_eq("t3_dx_valid_empty", dx_out_0_valid, 0);
      end
      idle(1);
      push_act(8'd2, c_act);
      @(negedge clk);
      check_eq("t3_dy_ready_next", dy_in_0_ready, 1);
      @(posedge clk);
      #1;
      dy_in_0_valid = 1'b0;
      @(negedge clk);
      check_eq("t3_dx_valid_lat", dx_out_0_valid, 1);
      check_eq("t3_dx_data", dx_out_0, 33);
      idle(3);
      check_drained("t3");

      // 16-beat stream under random backpressure
      out_log.delete();
      rand_on = 1'b1;
      fork
         begin
            int c;
            for (int i = 0; i < 16; i++) push_act(t4_act[i], c);
         end
         begin
            int c;
            for (int i = 0; i < 16; i++) begin
               if ($urandom_range(0, 3) == 0) idle(1);
               send_dy(8'($urandom_range(1, 255)), c);
            end
         end
      join
      rand_on        = 1'b0;
      dx_out_0_ready = 1'b1;
      idle(4);
      check_eq("t4_out_count", out_log.size(), 16);
      check_drained("t4");

      // throughput with the output always ready
      for (int i = 0; i < 4; i++) push_act(8'd3, c_act);
      fork
         begin
            int c;
            for (int i = 0; i < 4; i++) push_act(8'd1, c);
         end
         begin
            int c;
            for (int i = 0; i < 8; i++) begin
               send_dy(8'(40 + i), c);
               if (i == 0) c_first = c;
               c_last = c;
            end
         end
      join
      check_eq("t4_throughput", c_last - c_first, 7);
      idle(3);
      check_drained("t4b");

      // reset mid-operation with a stalled output beat
      dx_out_0_ready = 1'b0;
      for (int i = 0; i < 4; i++) push_act(8'(i + 1), c_act);
      send_dy(8'd9, c_dy);
      @(negedge clk);
      check_eq("t5_count_pre", mask_count, 3);
      check_eq("t5_valid_pre", dx_out_0_valid, 1);
      idle(1);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      @(negedge clk);
      check_eq("t5_count_post", mask_count, 0);
      check_eq("t5_valid_post", dx_out_0_valid, 0);
      check_eq("t5_dx_post", dx_out_0, 0);
      idle(1);
      dx_out_0_ready = 1'b1;
      out_log.delete();
      fork
         begin
            int c;
            push_act(8'd2, c);
            push_act(8'hFF, c);
         end
         begin
            int c;
            send_dy(8'd7, c);
            send_dy(8'd7, c);
         end
      join
      idle(3);
      check_eq("t5_out_count", out_log.size(), 2);
      if (out_log.size() == 2) begin
         check_eq("t5_dx_first", out_log[0], 7);
         check_eq("t5_dx_second", out_log[1], 0);
      end
      check_drained("t5");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/fixed_relu6_backward.md
FIXED_RELU6_BACKWARD -- requirements
Module: fixed_relu6_backward

Interface
REQ-001 SHALL have parameter DATA_IN_0_PRECISION_0, default 8: activation word width (signed two's complement).
REQ-002 SHALL have parameter DATA_IN_0_PRECISION_1, default 3: activation fractional bits (informational only; no arithmetic depends on it).
REQ-003 SHALL have parameter GRAD_PRECISION_0, default 8: gradient word width (signed).
REQ-004 SHALL have parameter DATA_IN_0_PARALLELISM_DIM_0, default 1, and DATA_IN_0_PARALLELISM_DIM_1, default 1; P = DIM_0*DIM_1 lanes per beat.
REQ-005 SHALL have parameter MASK_FIFO_DEPTH, default 8: number of mask beats buffered; power of two, >= 2.
REQ-006 SHALL have one clock and a synchronous, active-high reset, with ports ordered as follows:
- rst, input, 1: synchronous active-high reset.
- clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 SHALL have the activation-input stream:
- act_in_0, input, P x DATA_IN_0_PRECISION_0: forward-pass activations (pre-ReLU6).
- act_in_0_valid, input, 1: activation beat valid.
- act_in_0_ready, output, 1: activation beat accepted when valid and ready.
REQ-008 SHALL have the upstream-gradient stream:
- dy_in_0, input, P x GRAD_PRECISION_0: gradient of the ReLU6 output.
- dy_in_0_valid, input, 1: gradient beat valid.
- dy_in_0_ready, output, 1: gradient beat accepted when valid and ready.
REQ-009 SHALL have the output-gradient stream and status output:
- dx_out_0, output, P x GRAD_PRECISION_0: gradient of the ReLU6 input.
- dx_out_0_valid, output, 1: output beat valid.
- dx_out_0_ready, input, 1: downstream ready.
- mask_count, output, clog2(MASK_FIFO_DEPTH+1): number of buffered mask beats.

Function
REQ-010 SHALL compute, for each accepted activation beat, a P-bit mask; lane i bit = 1 iff signed act_in_0[i] > 0 and signed act_in_0[i] <= raw code 6, else 0.
REQ-011 SHALL push the mask into a FIFO of MASK_FIFO_DEPTH entries on every act_in_0 handshake; act_in_0_ready = !full, combinational from registered state only.
REQ-012 SHALL drive dy_in_0_ready = !empty && (!dx_out_0_valid || dx_out_0_ready).
REQ-013 SHALL, on a dy_in_0 handshake, pop the FIFO head mask and register dx_out_0[i] = mask[i] ? dy_in_0[i] : 0 for all lanes.
REQ-014 SHALL set dx_out_0_valid on that clock edge: latency from dy handshake to dx_out_0_valid is exactly 1 cycle.
REQ-015 SHALL hold dx_out_0 and dx_out_0_valid stable while dx_out_0_valid && !dx_out_0_ready.
REQ-016 SHALL clear dx_out_0_valid when dx_out_0_ready is high and no new dy handshake occurs in that cycle.
REQ-017 SHALL sustain one beat per cycle with the output held ready and the FIFO non-empty.
REQ-018 SHALL provide no empty-FIFO bypass: a mask pushed at edge N is poppable from the cycle after edge N.
REQ-019 SHALL, on simultaneous push and pop in one cycle, keep occupancy unchanged, including when the FIFO holds exactly one entry.
REQ-020 SHALL NOT push when full, since act_in_0_ready = 0; a pop in the same cycle does not enable a push in that cycle.
REQ-021 SHALL wrap the read and write pointers modulo MASK_FIFO_DEPTH, with full/empty distinguished by an extra pointer bit or the occupancy counter.
REQ-022 SHALL drive mask_count equal to the registered occupancy, range 0..MASK_FIFO_DEPTH.
REQ-023 SHALL pair gradient beats with mask beats strictly in arrival order.

Reset
REQ-024 SHALL, while rst is high at a clock edge, set dx_out_0_valid = 0, dx_out_0 = all zeros, FIFO pointers = 0, and mask_count = 0; act_in_0_ready and dy_in_0_ready read 1 and 0 respectively in the following cycle.
REQ-025 SHALL discard all buffered masks and any pending output beat when reset is asserted mid-operation; no handshake in a reset cycle has effect.

Verification
(P=1, widths 8, depth 4.)
REQ-026 SHALL cover: act -3, 0, 4, 6, 7 then dy 10 each -> dx 0, 0, 10, 10, 0, in order.
REQ-027 SHALL cover: 4 activations with no dy -> mask_count=4, act_in_0_ready=0; the 5th activation is held off until the first dy pop, after which it is accepted the next cycle.
REQ-028 SHALL cover: dy valid with the FIFO empty -> dy_in_0_ready=0 and dx_out_0_valid stays 0; an act pushed at edge N yields dy_ready=1 in cycle N+1 and dx valid after edge N+1.
REQ-029 SHALL cover: streaming 16 beats with dx_out_0_ready toggled randomly -> no loss or duplication, output stable while stalled, throughput 1/cycle when ready is held high.
REQ-030 SHALL cover: rst pulse with mask_count=3 and dx valid -> the next cycle shows mask_count=0, dx_out_0_valid=0, dx_out_0=0, and subsequent pairing restarts from new activations.
